// File: rtl/ff_sync_pkg.sv
// Shared constants and helpers for the multi-channel synchroniser/deglitcher.
package ff_sync_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_SYNC_STAGES = 4;
    localparam int unsigned MAX_FILT_CYCLES = 255;
    localparam int unsigned MAX_WIDTH       = 32;

    function automatic logic edge_hit(input edge_mode_e mode, input logic prev, input logic next);
        logic hit;
        case (mode)
            EDGE_RISE: hit = ~prev & next;
            EDGE_FALL: hit = prev & ~next;
            default:   hit = prev ^ next;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ff_sync_deglitch_ch.sv
// One channel: synchroniser chain, optional stability filter, edge detect and sticky flag.
module ff_sync_deglitch_ch
    import ff_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 0,
    parameter edge_mode_e  EDGE_MODE   = EDGE_RISE,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    input  logic event_clr,
    output logic sync_out,
    output logic edge_pulse,
    output logic event_flag
);

    (* async_reg = "true" *) logic [SYNC_STAGES-1:0] chain;
    logic s;
    logic level_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RST_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign s = chain[SYNC_STAGES-1];

    generate
        if (FILT_CYCLES == 0) begin : g_bypass
            // The last chain stage is the output; its next value is the stage before it,
            // which lets the pulse register line up with the output change.
            assign sync_out  = s;
            assign level_nxt = chain[SYNC_STAGES-2];
        end else begin : g_filter
            localparam int unsigned CNT_W = $clog2(FILT_CYCLES + 1);

            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] cnt_nxt;
            logic             level_q;

            always_comb begin
                level_nxt = level_q;
                cnt_nxt   = '0;
                if (s != level_q) begin
                    if (cnt == CNT_W'(FILT_CYCLES - 1)) begin
                        level_nxt = s;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt     <= '0;
                    level_q <= RST_VAL;
                end else begin
                    cnt     <= cnt_nxt;
                    level_q <= level_nxt;
                end
            end

            assign sync_out = level_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_pulse <= 1'b0;
            event_flag <= 1'b0;
        end else begin
            edge_pulse <= edge_hit(EDGE_MODE, sync_out, level_nxt);
            // Set has priority over a clear sampled in the same cycle.
            event_flag <= edge_pulse | (event_flag & ~event_clr);
        end
    end

endmodule

// File: rtl/ff_sync_deglitch.sv
// WIDTH independent asynchronous inputs, each synchronised, deglitched and edge-detected.
module ff_sync_deglitch
    import ff_sync_pkg::*;
#(
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      FILT_CYCLES = 0,
    parameter edge_mode_e       EDGE_MODE   = EDGE_RISE,
    parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] edge_pulse,
    output logic [WIDTH-1:0] event_flag,
    input  logic [WIDTH-1:0] event_clr
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            ff_sync_deglitch_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_CYCLES (FILT_CYCLES),
                .EDGE_MODE   (EDGE_MODE),
                .RST_VAL     (RST_VAL[i])
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .async_in   (async_in[i]),
                .event_clr  (event_clr[i]),
                .sync_out   (sync_out[i]),
                .edge_pulse (edge_pulse[i]),
                .event_flag (event_flag[i])
            );
        end
    endgenerate

endmodule

// File: doc/ff_sync_deglitch.md
FF_SYNC_DEGLITCH -- requirements
Module: ff_sync_deglitch

Interface
REQ-001 Parameter WIDTH, default 4, number of independent asynchronous input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, flip-flops per channel synchroniser chain (2..4).
REQ-003 Parameter FILT_CYCLES, default 0, consecutive stable cycles required before accepting a level; 0 = filter bypassed (0..255).
REQ-004 Parameter EDGE_MODE, default EDGE_RISE, edge reported on edge_pulse/event_flag: EDGE_RISE, EDGE_FALL or EDGE_BOTH.
REQ-005 Parameter RST_VAL, default all-zero, WIDTH-bit reset level of every chain stage and of sync_out.
REQ-006 clk  input  1  single clock; all flops rising-edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 async_in  input  WIDTH  asynchronous levels, one per channel.
REQ-009 sync_out  output  WIDTH  synchronised, deglitched level per channel.
REQ-010 edge_pulse  output  WIDTH  one-cycle pulse per channel on a selected edge of sync_out.
REQ-011 event_flag  output  WIDTH  sticky per-channel record of a selected edge.
REQ-012 event_clr  input  WIDTH  synchronous per-channel clear of event_flag.

Function
REQ-013 Each channel samples async_in[i] through SYNC_STAGES flops; only the last stage (s[i]) feeds further logic.
REQ-014 FILT_CYCLES=0: sync_out[i] equals s[i]; latency SYNC_STAGES rising edges, counting the edge that first samples the new level.
REQ-015 FILT_CYCLES>0: per-channel counter, width clog2(FILT_CYCLES+1); cleared while s[i]==sync_out[i]; increments each cycle s[i]!=sync_out[i].
REQ-016 When counter==FILT_CYCLES-1 and s[i]!=sync_out[i], sync_out[i] takes s[i] on that edge and the counter clears; total latency SYNC_STAGES+FILT_CYCLES edges.
REQ-017 A level held in s[i] for fewer than FILT_CYCLES consecutive cycles shall not change sync_out[i]; counter restarts from 0 on return.
REQ-018 Counter shall never exceed FILT_CYCLES-1 (no wrap).
REQ-019 edge_pulse[i] high for exactly the first cycle sync_out[i] shows a new value, when the transition matches EDGE_MODE; registered, no combinational path from inputs.
REQ-020 event_flag[i] sets on the cycle edge_pulse[i] is high and holds until event_clr[i] is sampled high.
REQ-021 edge_pulse[i] and event_clr[i] high in the same cycle: event_flag[i] shall be 1 afterwards (set wins).
REQ-022 Channels fully independent; activity on one never affects another's latency or outputs.

Reset
REQ-023 rst_n low asynchronously forces chain stages and sync_out to RST_VAL, counters to 0, edge_pulse and event_flag to 0.
REQ-024 Reset mid-filter discards partial counts; reset does not itself produce an edge_pulse.
REQ-025 After release, an async_in level differing from RST_VAL propagates per REQ-014/016 and produces a normal edge_pulse.

Structure
REQ-026 Package ff_sync_pkg holds EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2 and the max-stage/max-filter constants.
REQ-027 Per-channel logic in sub-module ff_sync_deglitch_ch, instantiated WIDTH times via generate.
REQ-028 Chain flops carry the team's synchroniser attribute for placement/timing exclusion.

Verification
REQ-029 WIDTH=4, FILT=0, STAGES=2: async_in 0000->0001 before edge 0 -> sync_out=0001 after edge 1, edge_pulse[0]=1 for one cycle, event_flag=0001.
REQ-030 FILT=3: 2-cycle glitch on async_in[1] -> sync_out, edge_pulse, event_flag unchanged; 3-cycle-stable level -> sync_out[1] changes at edge STAGES+3.
REQ-031 EDGE_MODE=EDGE_FALL, 1->0->1 on channel 2 -> exactly one edge_pulse[2], on the fall; EDGE_BOTH -> two pulses.
REQ-032 event_clr[3] asserted in the same cycle as edge_pulse[3] -> event_flag[3]=1; event_clr[3] one cycle later -> event_flag[3]=0.
REQ-033 rst_n low mid-count with FILT=4 -> outputs RST_VAL/0 immediately, no pulse; after release stable input takes full STAGES+4 cycles.
REQ-034 Random async_in toggles on all channels vs. cycle model -> sync_out never changes on a level stable < FILT_CYCLES cycles; pulses match model.
